// File: rtl/clk_cpu_monitor.sv
// rtl/clk_cpu_monitor.sv - board-clock observer of the divided CPU clock
// Synchronises Clk_CPU, detects rising edges, measures period, counts edges, flags stalls.
module clk_cpu_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 134217728,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Clk_CPU,
  input  logic             clr,
  output logic             edge_pulse,
  output logic [CNT_W-1:0] edge_count,
  output logic [31:0]      period,
  output logic             period_valid,
  output logic             period_changed,
  output logic             stalled
);

  localparam logic [31:0] L_TIMEOUT    = 32'(TIMEOUT);
  localparam logic [31:0] L_TIMEOUT_M1 = L_TIMEOUT - 32'd1;

  typedef enum logic [1:0] {IDLE, ARMED, LOCKED, STALLED} state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [31:0]            r_cnt;
  state_t                 r_state;
  state_t                 w_next;
  logic                   w_rise;
  logic                   w_timeout;
  logic [31:0]            w_meas;
  logic                   w_take_period;
  logic                   w_changed;

  assign w_rise    = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign w_timeout = (r_cnt == L_TIMEOUT_M1) && !w_rise;
  assign w_meas    = r_cnt + 32'd1;

  // Synchroniser and prev are deliberately immune to clr so clearing never fakes an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], Clk_CPU};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr || w_rise) begin
      r_cnt <= '0;
    end else if (r_cnt != L_TIMEOUT) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_take_period = 1'b0;
    w_changed     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise)         w_next = ARMED;
        else if (w_timeout) w_next = STALLED;
      end
      ARMED: begin
        if (w_rise) begin
          w_next        = LOCKED;
          w_take_period = 1'b1;
        end else if (w_timeout) begin
          w_next = STALLED;
        end
      end
      LOCKED: begin
        if (w_rise) begin
          w_take_period = 1'b1;
          w_changed     = (w_meas != period);
        end else if (w_timeout) begin
          w_next = STALLED;
        end
      end
      STALLED: begin
        if (w_rise) w_next = ARMED;
      end
      default: w_next = IDLE;
    endcase
    if (clr) begin
      w_next        = IDLE;
      w_take_period = 1'b0;
      w_changed     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_pulse     <= 1'b0;
      edge_count     <= '0;
      period         <= '0;
      period_valid   <= 1'b0;
      period_changed <= 1'b0;
      stalled        <= 1'b0;
    end else if (clr) begin
      edge_pulse     <= 1'b0;
      edge_count     <= '0;
      period         <= '0;
      period_valid   <= 1'b0;
      period_changed <= 1'b0;
      stalled        <= 1'b0;
    end else begin
      edge_pulse     <= w_rise;
      if (w_rise) edge_count <= edge_count + CNT_W'(1);
      if (w_take_period) period <= w_meas;
      period_valid   <= (w_next == LOCKED);
      period_changed <= w_changed;
      stalled        <= (w_next == STALLED);
    end
  end

endmodule

// File: tb/tb_clk_cpu_monitor.sv
// tb/tb_clk_cpu_monitor.sv - scoreboard bench for clk_cpu_monitor
module tb_clk_cpu_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Clk_CPU = 1'b0;
  logic        clr = 1'b0;
  logic        edge_pulse;
  logic [3:0]  edge_count;
  logic [31:0] period;
  logic        period_valid;
  logic        period_changed;
  logic        stalled;

  typedef struct {
    int          cyc;
    logic [3:0]  cnt;
    logic [31:0] per;
    logic        val;
    logic        chg;
    logic        stl;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   n_rises = 0;
  int   last_pulse = 0;

  clk_cpu_monitor #(.SYNC_STAGES(2), .TIMEOUT(100), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .Clk_CPU(Clk_CPU), .clr(clr),
    .edge_pulse(edge_pulse), .edge_count(edge_count), .period(period),
    .period_valid(period_valid), .period_changed(period_changed), .stalled(stalled)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && edge_pulse) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse cyc=%0d edge_pulse got 1 expected 0", cyc);
      end else begin
        mon_e = sb.pop_front();
        if (cyc !== mon_e.cyc) begin
          bad++; $display("FAIL pulse_latency got cyc %0d expected %0d", cyc, mon_e.cyc);
        end
        total++;
        if (edge_count !== mon_e.cnt) begin
          bad++; $display("FAIL edge_count got %0d expected %0d", edge_count, mon_e.cnt);
        end
        total++;
        if (period !== mon_e.per) begin
          bad++; $display("FAIL period got %0d expected %0d", period, mon_e.per);
        end
        total++;
        if (period_valid !== mon_e.val) begin
          bad++; $display("FAIL period_valid got %0b expected %0b", period_valid, mon_e.val);
        end
        total++;
        if (period_changed !== mon_e.chg) begin
          bad++; $display("FAIL period_changed got %0b expected %0b", period_changed, mon_e.chg);
        end
        total++;
        if (stalled !== mon_e.stl) begin
          bad++; $display("FAIL stalled_at_pulse got %0b expected %0b", stalled, mon_e.stl);
        end
      end
      last_pulse = cyc;
    end
  end

  task automatic wave(input int h, input int per, input bit val, input bit chg, input bit stl);
    exp_t x;
    @(negedge clk);
    Clk_CPU = 1'b1;
    n_rises++;
    x.cyc = cyc + 3;
    x.cnt = 4'(n_rises % 16);
    x.per = 32'(per);
    x.val = val;
    x.chg = chg;
    x.stl = stl;
    sb.push_back(x);
    repeat (h - 1) @(negedge clk);
    @(negedge clk);
    Clk_CPU = 1'b0;
    repeat (h - 1) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++;
    if ({edge_pulse, edge_count, period, period_valid, period_changed, stalled} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got pulse=%0b cnt=%0d per=%0d val=%0b chg=%0b stl=%0b expected all 0",
               edge_pulse, edge_count, period, period_valid, period_changed, stalled);
    end
    rst = 1'b0;
  endtask

  task automatic test_first_lock;
    wave(8, 0, 0, 0, 0);
    wave(8, 16, 1, 0, 0);
    wave(8, 16, 1, 0, 0);
  endtask

  task automatic test_period_change;
    wave(16, 16, 1, 0, 0);
    wave(16, 32, 1, 1, 0);
    wave(16, 32, 1, 0, 0);
    wave(16, 32, 1, 0, 0);
  endtask

  task automatic test_stall;
    int i;
    i = 0;
    while (stalled !== 1'b1 && i < 400) begin
      @(negedge clk);
      i++;
    end
    total++;
    if (stalled !== 1'b1) begin
      bad++; $display("FAIL stall_assert got %0b expected 1", stalled);
    end
    total++;
    if (cyc !== last_pulse + 100) begin
      bad++; $display("FAIL stall_timing got cyc %0d expected %0d", cyc, last_pulse + 100);
    end
    total++;
    if (period_valid !== 1'b0) begin
      bad++; $display("FAIL stall_valid got %0b expected 0", period_valid);
    end
    total++;
    if (period !== 32'd32) begin
      bad++; $display("FAIL stall_period got %0d expected 32", period);
    end
    wave(16, 32, 0, 0, 0);
    wave(16, 32, 1, 0, 0);
    wave(16, 32, 1, 0, 0);
  endtask

  task automatic test_clr_on_rise;
    @(negedge clk);
    Clk_CPU = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_rises = 0;
    total++;
    if ({edge_pulse, edge_count, period, period_valid, stalled} !== '0) begin
      bad++;
      $display("FAIL clr_on_rise got pulse=%0b cnt=%0d per=%0d val=%0b stl=%0b expected all 0",
               edge_pulse, edge_count, period, period_valid, stalled);
    end
    repeat (5) @(negedge clk);
    Clk_CPU = 1'b0;
    repeat (7) @(negedge clk);
    wave(8, 0, 0, 0, 0);
    wave(8, 16, 1, 0, 0);
  endtask

  task automatic test_wrap;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_rises = 0;
    total++;
    if (edge_count !== 4'd0) begin
      bad++; $display("FAIL clr_count got %0d expected 0", edge_count);
    end
    wave(8, 0, 0, 0, 0);
    for (int i = 1; i < 17; i++) wave(8, 16, 1, 0, 0);
  endtask

  task automatic test_async_rst;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    total++;
    if ({edge_pulse, edge_count, period, period_valid, period_changed, stalled} !== '0) begin
      bad++;
      $display("FAIL async_rst got pulse=%0b cnt=%0d per=%0d val=%0b chg=%0b stl=%0b expected all 0",
               edge_pulse, edge_count, period, period_valid, period_changed, stalled);
    end
    @(negedge clk);
    rst = 1'b0;
    n_rises = 0;
    wave(8, 0, 0, 0, 0);
    wave(8, 16, 1, 0, 0);
  endtask

  initial begin
    test_reset();
    test_first_lock();
    test_period_change();
    test_stall();
    test_clr_on_rise();
    test_wrap();
    test_async_rst();
    repeat (5) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL missing_pulses got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
